// File: rtl/sprite_engine_if.sv
// sprite_engine_if -- bundle of the sprite engine's configuration bus, the
// pixel query inputs and the per-pixel result outputs.
//
// Signals:
//   cfg_we               configuration write strobe
//   cfg_id               sprite index being written
//   cfg_x, cfg_y         new top-left position (10b unsigned)
//   cfg_vx, cfg_vy       new per-frame velocity (4b two's complement)
//   cfg_en               new enable for that sprite
//   DrawX, DrawY         pixel currently being drawn
//   frame_tick           one-cycle pulse per frame
//   hit_mask             per-sprite coverage of the pixel one cycle ago
//   is_sprite            any bit of hit_mask set
//   sprite_id            lowest-index covering sprite (0 when none)
//   sprite_addr          pixel offset inside that sprite's image (0 when none)
//
// Handshake: cfg_we is a single-cycle write strobe with no ready/backpressure.
// Every cycle in which cfg_we is high commits exactly one write, captured
// together with cfg_id/cfg_x/cfg_y/cfg_vx/cfg_vy/cfg_en at that rising edge.
// DrawX/DrawY are sampled every cycle; the result outputs always describe the
// pixel presented on the previous cycle.
//
// modport master : drives configuration and pixel query (video controller)
// modport slave  : the sprite engine itself
interface sprite_engine_if #(
    parameter int N_SPR = 4,
    parameter int IDW   = (N_SPR > 1) ? $clog2(N_SPR) : 1,
    parameter int AW    = 12
);
    logic             cfg_we;
    logic [IDW-1:0]   cfg_id;
    logic [9:0]       cfg_x;
    logic [9:0]       cfg_y;
    logic [3:0]       cfg_vx;
    logic [3:0]       cfg_vy;
    logic             cfg_en;
    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             frame_tick;
    logic [N_SPR-1:0] hit_mask;
    logic             is_sprite;
    logic [IDW-1:0]   sprite_id;
    logic [AW-1:0]    sprite_addr;

    modport master (
        output cfg_we, cfg_id, cfg_x, cfg_y, cfg_vx, cfg_vy, cfg_en,
        output DrawX, DrawY,
        input  frame_tick, hit_mask, is_sprite, sprite_id, sprite_addr
    );

    modport slave (
        input  cfg_we, cfg_id, cfg_x, cfg_y, cfg_vx, cfg_vy, cfg_en,
        input  DrawX, DrawY,
        output frame_tick, hit_mask, is_sprite, sprite_id, sprite_addr
    );
endinterface

// File: rtl/sprite_engine.sv
// sprite_engine -- N_SPR bouncing sprites with per-pixel hit detection.
//
// Each sprite holds a top-left position and a signed per-frame velocity.
// Once per frame (rising edge of the synchronised vertical sync) every
// enabled sprite steps by its velocity and bounces off the screen edges.
// For every pixel presented on DrawX/DrawY the engine reports, one cycle
// later, which sprites cover it, the highest-priority (lowest index) one,
// and the pixel offset inside that sprite's ROM image.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   frame_clk  in   vertical sync, asynchronous to Clk, idle high
//   bus        slave modport of sprite_engine_if (config, pixel query, results)
module sprite_engine #(
    parameter int N_SPR = 4,
    parameter int SPR_W = 64,
    parameter int SPR_H = 64,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int IDW   = (N_SPR > 1) ? $clog2(N_SPR) : 1,
    parameter int AW    = $clog2(SPR_W * SPR_H)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    sprite_engine_if.slave   bus
);

    // Largest legal top-left coordinate on each axis: the sprite's last
    // column/row then lands exactly on X_MAX/Y_MAX.
    localparam logic signed [11:0] LIM_X = 12'(X_MAX + 1 - SPR_W);
    localparam logic signed [11:0] LIM_Y = 12'(Y_MAX + 1 - SPR_H);

    typedef struct packed {
        logic [9:0] pos;
        logic [3:0] vel;
    } axis_t;

    // ------------------------------------------------------------------
    // Frame tick: two synchroniser flops, one edge flop, registered pulse.
    // All three flops reset to 1 (the idle level of vsync) so releasing
    // reset with frame_clk high cannot be mistaken for a rising edge.
    // ------------------------------------------------------------------
    logic sync_a;
    logic sync_b;
    logic sync_c;
    logic tick_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            sync_c <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            sync_a <= frame_clk;
            sync_b <= sync_a;
            sync_c <= sync_b;
            tick_q <= sync_b & ~sync_c;
        end
    end

    assign bus.frame_tick = tick_q;

    // ------------------------------------------------------------------
    // Motion helpers
    // ------------------------------------------------------------------

    // Negate a 4-bit velocity; -8 has no positive counterpart so it
    // saturates to +7.
    function automatic logic [3:0] neg_sat(input logic [3:0] v);
        if (v == 4'b1000) begin
            return 4'b0111;
        end
        return 4'(~v + 4'd1);
    endfunction

    // One frame step on one axis, done in 12-bit signed arithmetic so
    // that stepping below zero or past the limit is visible before
    // clamping. A zero velocity gives n == pos and never flips sign.
    function automatic axis_t step_axis(input logic [9:0]         pos,
                                        input logic [3:0]         vel,
                                        input logic signed [11:0] lim);
        axis_t             r;
        logic signed [11:0] n;
        n     = $signed({2'b00, pos}) + $signed({{8{vel[3]}}, vel});
        r.pos = pos;
        r.vel = vel;
        if (n < 12'sd0) begin
            r.pos = 10'd0;
            r.vel = neg_sat(vel);
        end else if (n > lim) begin
            r.pos = lim[9:0];
            r.vel = neg_sat(vel);
        end else begin
            r.pos = n[9:0];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Sprite state
    // ------------------------------------------------------------------
    logic [9:0]       spr_x  [N_SPR];
    logic [9:0]       spr_y  [N_SPR];
    logic [3:0]       spr_vx [N_SPR];
    logic [3:0]       spr_vy [N_SPR];
    logic [N_SPR-1:0] spr_en;

    axis_t            nxt_x  [N_SPR];
    axis_t            nxt_y  [N_SPR];
    logic             cfg_valid;

    // Writes to indices beyond the last channel are dropped.
    assign cfg_valid = bus.cfg_we &&
                       ({1'b0, bus.cfg_id} < (IDW + 1)'(N_SPR));

    always_comb begin
        for (int i = 0; i < N_SPR; i++) begin
            nxt_x[i] = step_axis(spr_x[i], spr_vx[i], LIM_X);
            nxt_y[i] = step_axis(spr_y[i], spr_vy[i], LIM_Y);
        end
    end

    // A configuration write takes precedence over motion for the written
    // sprite only; every other enabled sprite still moves on the tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_SPR; i++) begin
                spr_x[i]  <= 10'd0;
                spr_y[i]  <= 10'd0;
                spr_vx[i] <= 4'd0;
                spr_vy[i] <= 4'd0;
            end
            spr_en <= '0;
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                if (cfg_valid && (bus.cfg_id == IDW'(i))) begin
                    spr_x[i]  <= bus.cfg_x;
                    spr_y[i]  <= bus.cfg_y;
                    spr_vx[i] <= bus.cfg_vx;
                    spr_vy[i] <= bus.cfg_vy;
                    spr_en[i] <= bus.cfg_en;
                end else if (tick_q && spr_en[i]) begin
                    spr_x[i]  <= nxt_x[i].pos;
                    spr_vx[i] <= nxt_x[i].vel;
                    spr_y[i]  <= nxt_y[i].pos;
                    spr_vy[i] <= nxt_y[i].vel;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel hit test and priority select
    // ------------------------------------------------------------------
    logic [N_SPR-1:0] hit_c;
    logic [AW-1:0]    off_c [N_SPR];
    logic [IDW-1:0]   win_id;
    logic [AW-1:0]    win_addr;

    // Bounds are compared with 11-bit sums so a sprite whose right or
    // bottom edge extends past 1023 does not wrap around to column 0.
    always_comb begin
        logic [9:0] dx;
        logic [9:0] dy;
        dx = 10'd0;
        dy = 10'd0;
        for (int i = 0; i < N_SPR; i++) begin
            hit_c[i] = spr_en[i] &&
                       ({1'b0, bus.DrawX} >= {1'b0, spr_x[i]}) &&
                       ({1'b0, bus.DrawX} <= ({1'b0, spr_x[i]} + 11'(SPR_W - 1))) &&
                       ({1'b0, bus.DrawY} >= {1'b0, spr_y[i]}) &&
                       ({1'b0, bus.DrawY} <= ({1'b0, spr_y[i]} + 11'(SPR_H - 1)));
            dx       = bus.DrawX - spr_x[i];
            dy       = bus.DrawY - spr_y[i];
            off_c[i] = AW'(dy) * AW'(SPR_W) + AW'(dx);
        end
    end

    // Walk from the highest index down so the lowest hit index is the
    // last assignment and therefore wins.
    always_comb begin
        win_id   = '0;
        win_addr = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                win_id   = IDW'(i);
                win_addr = off_c[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers (one cycle after DrawX/DrawY)
    // ------------------------------------------------------------------
    logic [N_SPR-1:0] hit_q;
    logic             any_q;
    logic [IDW-1:0]   id_q;
    logic [AW-1:0]    addr_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_q  <= '0;
            any_q  <= 1'b0;
            id_q   <= '0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_c;
            any_q  <= |hit_c;
            id_q   <= win_id;
            addr_q <= win_addr;
        end
    end

    assign bus.hit_mask    = hit_q;
    assign bus.is_sprite   = any_q;
    assign bus.sprite_id   = id_q;
    assign bus.sprite_addr = addr_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine -- directed bench for sprite_engine with 4 sprites of
// 64x64 on a 640x480 screen. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, away from the active edge.
module tb_sprite_engine;

    localparam int N_SPR = 4;
    localparam int IDW   = 2;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst;
    logic frame_clk;

    int checks = 0;
    int errors = 0;

    sprite_engine_if #(.N_SPR(N_SPR), .IDW(IDW), .AW(AW)) bus ();

    sprite_engine #(
        .N_SPR(N_SPR), .SPR_W(64), .SPR_H(64), .X_MAX(639), .Y_MAX(479),
        .IDW(IDW), .AW(AW)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [1:0] id, input logic [9:0] x,
                             input logic [9:0] y, input logic [3:0] vx,
                             input logic [3:0] vy, input logic en);
        bus.cfg_id = id;
        bus.cfg_x  = x;
        bus.cfg_y  = y;
        bus.cfg_vx = vx;
        bus.cfg_vy = vy;
        bus.cfg_en = en;
        bus.cfg_we = 1'b1;
        step_cycle();
        bus.cfg_we = 1'b0;
    endtask

    // Present a pixel; the registered result is visible on return.
    task automatic probe(input logic [9:0] dx, input logic [9:0] dy);
        bus.DrawX = dx;
        bus.DrawY = dy;
        step_cycle();
    endtask

    // Produce one vsync rising edge, wait (bounded) for the tick pulse,
    // then let the movement edge happen.
    task automatic do_frame();
        logic found;
        frame_clk = 1'b0;
        repeat (4) step_cycle();
        frame_clk = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step_cycle();
            if (bus.frame_tick) begin
                found = 1'b1;
                break;
            end
        end
        check("tick_seen", 32'(found), 32'd1);
        step_cycle();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int ticks;
        int tick_at;

        // Reset, with a write to id1 presented at the same time.
        rst        = 1'b1;
        frame_clk  = 1'b1;
        bus.DrawX  = 10'd0;
        bus.DrawY  = 10'd0;
        bus.cfg_id = 2'd1;
        bus.cfg_x  = 10'd0;
        bus.cfg_y  = 10'd0;
        bus.cfg_vx = 4'd0;
        bus.cfg_vy = 4'd0;
        bus.cfg_en = 1'b1;
        bus.cfg_we = 1'b1;
        repeat (3) step_cycle();
        check("rst_tick", 32'(bus.frame_tick), 32'd0);
        check("rst_mask", 32'(bus.hit_mask), 32'd0);
        check("rst_any", 32'(bus.is_sprite), 32'd0);
        check("rst_id", 32'(bus.sprite_id), 32'd0);
        check("rst_addr", 32'(bus.sprite_addr), 32'd0);
        rst        = 1'b0;
        bus.cfg_we = 1'b0;

        // No spurious tick after release with frame_clk high; the write
        // issued under reset was dropped, so (0,0) is not covered.
        ticks = 0;
        for (int k = 0; k < 6; k++) begin
            step_cycle();
            if (bus.frame_tick) ticks++;
        end
        check("post_rst_ticks", 32'(ticks), 32'd0);
        check("rst_write_dropped", 32'(bus.is_sprite), 32'd0);

        // Single sprite, corners and just outside.
        write_cfg(2'd1, 10'd100, 10'd50, 4'd0, 4'd0, 1'b1);
        probe(10'd100, 10'd50);
        check("s1_tl_mask", 32'(bus.hit_mask), 32'b0010);
        check("s1_tl_any", 32'(bus.is_sprite), 32'd1);
        check("s1_tl_id", 32'(bus.sprite_id), 32'd1);
        check("s1_tl_addr", 32'(bus.sprite_addr), 32'd0);
        probe(10'd163, 10'd113);
        check("s1_br_mask", 32'(bus.hit_mask), 32'b0010);
        check("s1_br_addr", 32'(bus.sprite_addr), 32'd4095);
        probe(10'd164, 10'd113);
        check("s1_right_any", 32'(bus.is_sprite), 32'd0);
        check("s1_right_id", 32'(bus.sprite_id), 32'd0);
        check("s1_right_addr", 32'(bus.sprite_addr), 32'd0);
        probe(10'd99, 10'd50);
        check("s1_left_any", 32'(bus.is_sprite), 32'd0);

        // Overlap: id0 beats id2, mask shows both.
        write_cfg(2'd0, 10'd200, 10'd200, 4'd0, 4'd0, 1'b1);
        write_cfg(2'd2, 10'd200, 10'd200, 4'd0, 4'd0, 1'b1);
        probe(10'd210, 10'd205);
        check("ovl_mask", 32'(bus.hit_mask), 32'b0101);
        check("ovl_id", 32'(bus.sprite_id), 32'd0);
        check("ovl_addr", 32'(bus.sprite_addr), 32'd330);
        write_cfg(2'd0, 10'd200, 10'd200, 4'd0, 4'd0, 1'b0);
        write_cfg(2'd2, 10'd200, 10'd200, 4'd0, 4'd0, 1'b0);
        probe(10'd210, 10'd205);
        check("ovl_off_mask", 32'(bus.hit_mask), 32'b0000);

        // Right-edge bounce: 574+5 -> clamp 576, vx -> -5, then 571.
        write_cfg(2'd0, 10'd574, 10'd0, 4'd5, 4'd0, 1'b1);
        do_frame();
        probe(10'd576, 10'd0);
        check("bx1_in_mask", 32'(bus.hit_mask), 32'b0001);
        check("bx1_in_addr", 32'(bus.sprite_addr), 32'd0);
        probe(10'd575, 10'd0);
        check("bx1_out_mask", 32'(bus.hit_mask), 32'b0000);
        probe(10'd639, 10'd63);
        check("bx1_corner_addr", 32'(bus.sprite_addr), 32'd4095);
        do_frame();
        probe(10'd571, 10'd0);
        check("bx2_in_mask", 32'(bus.hit_mask), 32'b0001);
        probe(10'd570, 10'd0);
        check("bx2_out_mask", 32'(bus.hit_mask), 32'b0000);

        // Top-edge bounce with vy=-8: 2-8 -> clamp 0, vy -> +7, then 7.
        write_cfg(2'd3, 10'd0, 10'd2, 4'd0, 4'h8, 1'b1);
        do_frame();
        probe(10'd0, 10'd0);
        check("by1_mask", 32'(bus.hit_mask), 32'b1000);
        check("by1_id", 32'(bus.sprite_id), 32'd3);
        check("by1_addr", 32'(bus.sprite_addr), 32'd0);
        do_frame();
        probe(10'd0, 10'd7);
        check("by2_in_mask", 32'(bus.hit_mask), 32'b1000);
        probe(10'd0, 10'd6);
        check("by2_out_mask", 32'(bus.hit_mask), 32'b0000);
        probe(10'd5, 10'd10);
        check("by2_addr", 32'(bus.sprite_addr), 32'd197);

        // Zero-velocity sprite stays put after several frames.
        probe(10'd100, 10'd50);
        check("still_mask", 32'(bus.hit_mask), 32'b0010);
        check("still_addr", 32'(bus.sprite_addr), 32'd0);

        // Long low vsync then rise: exactly one tick, 3 cycles after the
        // rise; a write to id0 on that cycle wins over movement.
        frame_clk = 1'b0;
        ticks = 0;
        for (int k = 0; k < 1000; k++) begin
            step_cycle();
            if (bus.frame_tick) ticks++;
        end
        check("low_ticks", 32'(ticks), 32'd0);
        frame_clk = 1'b1;
        ticks   = 0;
        tick_at = 0;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            bus.cfg_we = 1'b0;
            if (bus.frame_tick) begin
                ticks++;
                if (ticks == 1) begin
                    tick_at    = k;
                    bus.cfg_id = 2'd0;
                    bus.cfg_x  = 10'd300;
                    bus.cfg_y  = 10'd300;
                    bus.cfg_vx = 4'd3;
                    bus.cfg_vy = 4'd3;
                    bus.cfg_en = 1'b1;
                    bus.cfg_we = 1'b1;
                end
            end
        end
        check("rise_ticks", 32'(ticks), 32'd1);
        check("rise_latency", 32'(tick_at), 32'd3);
        probe(10'd300, 10'd300);
        check("wr_tick_mask", 32'(bus.hit_mask), 32'b0001);
        check("wr_tick_addr", 32'(bus.sprite_addr), 32'd0);
        probe(10'd299, 10'd300);
        check("wr_tick_left", 32'(bus.hit_mask), 32'b0000);
        probe(10'd0, 10'd14);
        check("other_moved_in", 32'(bus.hit_mask), 32'b1000);
        probe(10'd0, 10'd13);
        check("other_moved_out", 32'(bus.hit_mask), 32'b0000);

        // Reset while a pixel is hitting and sprites are moving.
        bus.DrawX = 10'd300;
        bus.DrawY = 10'd300;
        step_cycle();
        check("pre_rst_any", 32'(bus.is_sprite), 32'd1);
        rst = 1'b1;
        step_cycle();
        check("mid_rst_mask", 32'(bus.hit_mask), 32'd0);
        check("mid_rst_any", 32'(bus.is_sprite), 32'd0);
        check("mid_rst_id", 32'(bus.sprite_id), 32'd0);
        check("mid_rst_addr", 32'(bus.sprite_addr), 32'd0);
        check("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
        rst = 1'b0;
        probe(10'd300, 10'd300);
        check("after_rst_a", 32'(bus.is_sprite), 32'd0);
        probe(10'd100, 10'd50);
        check("after_rst_b", 32'(bus.is_sprite), 32'd0);
        do_frame();
        probe(10'd0, 10'd14);
        check("after_rst_c", 32'(bus.is_sprite), 32'd0);
        probe(10'd0, 10'd0);
        check("after_rst_d", 32'(bus.hit_mask), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter N_SPR, default 4, number of sprite channels (1..8).
REQ-002 Parameter SPR_W, default 64, sprite width in pixels (power of two).
REQ-003 Parameter SPR_H, default 64, sprite height in pixels.
REQ-004 Parameter X_MAX, default 639, last visible column.
REQ-005 Parameter Y_MAX, default 479, last visible row.
REQ-006 Parameter IDW, default $clog2(N_SPR) (min 1), sprite index width.
REQ-007 Parameter AW, default $clog2(SPR_W*SPR_H), ROM address width.
REQ-008 Clk  in  1  system clock; all logic on rising edge.
REQ-009 Reset  in  1  synchronous, active-high reset.
REQ-010 frame_clk  in  1  VGA vertical sync, asynchronous to Clk, idle high.
REQ-011 DrawX  in  10  current pixel column.
REQ-012 DrawY  in  10  current pixel row.
REQ-013 cfg_we  in  1  configuration write strobe, one cycle.
REQ-014 cfg_id  in  IDW  sprite index written.
REQ-015 cfg_x, cfg_y  in  10 each  new top-left position.
REQ-016 cfg_vx, cfg_vy  in  4 each  signed two's-complement per-frame velocity.
REQ-017 cfg_en  in  1  sprite enable.
REQ-018 frame_tick  out  1  one-cycle pulse per frame.
REQ-019 hit_mask  out  N_SPR  per-sprite coverage of the current pixel.
REQ-020 is_sprite  out  1  any enabled sprite covers the current pixel.
REQ-021 sprite_id  out  IDW  index of the winning sprite.
REQ-022 sprite_addr  out  AW  pixel offset within the winning sprite's ROM image.

Function
REQ-023 frame_clk SHALL pass through a 2-flop synchroniser plus one edge flop; frame_tick = 1 for exactly one cycle on a synchronised 0->1 transition.
REQ-024 Per sprite, registers x, y (10b unsigned), vx, vy (4b signed), en SHALL be held.
REQ-025 cfg_we SHALL load x, y, vx, vy, en of sprite cfg_id at that clock edge; cfg_id >= N_SPR ignored.
REQ-026 On frame_tick, each enabled sprite: nx = x + sign-extended vx in 12-bit signed arithmetic.
REQ-027 If nx < 0: x <= 0, vx <= -vx; if nx > X_MAX+1-SPR_W: x <= X_MAX+1-SPR_W, vx <= -vx; else x <= nx.
REQ-028 Y axis SHALL follow REQ-026/027 using vy, SPR_H, Y_MAX.
REQ-029 vx = -8 reflects to +7 (saturated negate); vx = 0 never reflects.
REQ-030 Disabled sprites SHALL hold position and velocity on frame_tick.
REQ-031 cfg_we and frame_tick in the same cycle: written sprite takes cfg values, others move normally.
REQ-032 hit_mask[i] SHALL be registered, 1-cycle latency: en[i] and x<=DrawX<=x+SPR_W-1 and y<=DrawY<=y+SPR_H-1, evaluated with 11-bit sums (no wrap).
REQ-033 is_sprite = OR of hit_mask; registered in same cycle as hit_mask.
REQ-034 sprite_id SHALL be lowest hit index (index 0 highest priority); 0 when no hit.
REQ-035 sprite_addr = (DrawY-y)*SPR_W + (DrawX-x) of the winner, registered with hit_mask; 0 when no hit.
REQ-036 Overlapping sprites: only the winner's address is output; hit_mask shows all.

Reset
REQ-037 Reset SHALL clear all x, y, vx, vy, en to 0.
REQ-038 Reset SHALL set all three synchroniser/edge flops to 1, so no frame_tick in the first cycles after release.
REQ-039 Reset SHALL drive frame_tick, hit_mask, is_sprite, sprite_id, sprite_addr to 0 on the next edge.
REQ-040 Reset asserted together with cfg_we SHALL win; the write is discarded.

Verification
REQ-041 Write id1 x=100 y=50 en=1; DrawX=100 DrawY=50 -> next cycle hit_mask=0010, is_sprite=1, sprite_id=1, sprite_addr=0; DrawX=163 DrawY=113 -> addr 4095; DrawX=164 -> is_sprite=0.
REQ-042 id0 and id2 both at (200,200) enabled; DrawX=210 DrawY=205 -> hit_mask=0101, sprite_id=0, sprite_addr=330.
REQ-043 id0 x=574 vx=+5 en=1; one frame_tick -> x=576, vx=-5; next tick -> x=571.
REQ-044 id3 y=2 vy=-8; tick -> y=0, vy=+7; tick -> y=7.
REQ-045 frame_clk held low 1000 cycles then high -> exactly one frame_tick, 3 cycles after rise; cfg_we for id0 on that tick cycle -> cfg values retained, unmoved.
REQ-046 Reset mid-frame with sprites moving -> all outputs 0 next cycle, no hit at any pixel until re-configured.
